// File: rtl/xfer_bus_ctrl.sv
// Register file, channel registers and one shared mux bus, driven by a
// three-state (IDLE/RD/WR) sequencer that runs one transfer command at a time.
module xfer_bus_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  parameter  int NCH   = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fr_we,
  input  logic [AW-1:0]        fr_waddr,
  input  logic [WIDTH-1:0]     fr_wdata,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [CW-1:0]        cmd_ch,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     bus_data,
  output logic [NCH*WIDTH-1:0] ch_data
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_p0;
  logic [AW-1:0]    addr_p0;
  logic [CW-1:0]    ch_p0;
  logic [WIDTH-1:0] xfer_q;
  logic [WIDTH-1:0] file_r [DEPTH];
  logic [WIDTH-1:0] ch_r   [NCH];
  logic [WIDTH-1:0] file_rd, ch_src;
  logic [CW-1:0]    dst_idx;
  logic             err_w, commit, accept;

  // Decoded by equality so out-of-range indices simply match nothing.
  function automatic logic ch_in_range(input logic [CW-1:0] c);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (c == CW'(i)) ok = 1'b1;
    return ok;
  endfunction

  assign accept  = cmd_valid & cmd_ready;
  assign dst_idx = (op_p0 == OP_MOVE) ? addr_p0[CW-1:0] : ch_p0;
  assign err_w   = !ch_in_range(ch_p0) ||
                   ((op_p0 == OP_MOVE) && !ch_in_range(addr_p0[CW-1:0]));
  assign commit  = (state == S_WR) && !err_w;

  always_comb begin
    file_rd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr_p0 == AW'(i)) file_rd = file_r[i];
  end

  always_comb begin
    ch_src = '0;
    for (int i = 0; i < NCH; i++)
      if (ch_p0 == CW'(i)) ch_src = ch_r[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RD;
      S_RD:    state_nxt = S_WR;
      S_WR:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    bus_data  = '0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_WR: begin
        done     = 1'b1;
        err      = err_w;
        bus_data = xfer_q;
      end
      default: ;
    endcase
  end

  // Stage p0: command fields latched on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_p0   <= OP_LOAD;
      addr_p0 <= '0;
      ch_p0   <= '0;
    end else if (accept) begin
      op_p0   <= cmd_op;
      addr_p0 <= cmd_addr;
      ch_p0   <= cmd_ch;
    end
  end

  // Stage RD: source captured; a direct write on this same edge is not seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_q <= '0;
    end else if (state == S_RD) begin
      case (op_p0)
        OP_LOAD:  xfer_q <= file_rd;
        OP_STORE,
        OP_MOVE:  xfer_q <= ch_src;
        OP_CLEAR: xfer_q <= '0;
        default:  xfer_q <= '0;
      endcase
    end
  end

  // Stage WR: destination written; a STORE overrides a same-address direct write
  for (genvar g = 0; g < DEPTH; g++) begin : g_file
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        file_r[g] <= '0;
      else if (commit && (op_p0 == OP_STORE) && (addr_p0 == AW'(g)))
        file_r[g] <= xfer_q;
      else if (fr_we && (fr_waddr == AW'(g)))
        file_r[g] <= fr_wdata;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        ch_r[g] <= '0;
      else if (commit && (op_p0 != OP_STORE) && (dst_idx == CW'(g)))
        ch_r[g] <= xfer_q;
    end
    assign ch_data[g*WIDTH +: WIDTH] = ch_r[g];
  end

endmodule

// File: tb/tb_xfer_bus_ctrl.sv
// Directed bench for xfer_bus_ctrl: default instance (NCH=2, DEPTH=32) and a
// second instance with NCH=3, DEPTH=20 for index-error and address-range cases.
module tb_xfer_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fr_we, fr_we3;
  logic [4:0]  fr_waddr;
  logic [7:0]  fr_wdata;
  logic        cmd_valid, cmd_valid3;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [1:0]  cmd_ch;
  logic        cmd_ready, cmd_ready3;
  logic        done, done3, err, err3;
  logic [7:0]  bus_data, bus_data3;
  logic [15:0] ch_data;
  logic [23:0] ch_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xfer_bus_ctrl dut (
    .clk(clk), .rst(rst), .fr_we(fr_we), .fr_waddr(fr_waddr), .fr_wdata(fr_wdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_ch(cmd_ch[0:0]), .done(done), .err(err), .bus_data(bus_data), .ch_data(ch_data)
  );

  xfer_bus_ctrl #(.WIDTH(8), .DEPTH(20), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .fr_we(fr_we3), .fr_waddr(fr_waddr), .fr_wdata(fr_wdata),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_ch(cmd_ch), .done(done3), .err(err3), .bus_data(bus_data3), .ch_data(ch_data3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel3, input logic [4:0] a, input logic [7:0] d);
    fr_waddr = a;
    fr_wdata = d;
    if (sel3) fr_we3 = 1'b1; else fr_we = 1'b1;
    tick();
    fr_we  = 1'b0;
    fr_we3 = 1'b0;
  endtask

  // wr_phase 1: direct write on the edge ending RD; 2: on the commit edge.
  task automatic run_cmd(input bit sel3, input logic [1:0] op, input logic [4:0] a,
                         input logic [1:0] ch, input logic [7:0] exp_bus, input bit exp_err,
                         input int wr_phase, input logic [4:0] wa, input logic [7:0] wd,
                         input string tag);
    cmd_op   = op;
    cmd_addr = a;
    cmd_ch   = ch;
    if (sel3) cmd_valid3 = 1'b1; else cmd_valid = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
    chk({tag, ".rd_ready"}, sel3 ? cmd_ready3 : cmd_ready, 1'b0);
    chk({tag, ".rd_done"}, sel3 ? done3 : done, 1'b0);
    if (wr_phase == 1) begin
      fr_waddr = wa; fr_wdata = wd;
      if (sel3) fr_we3 = 1'b1; else fr_we = 1'b1;
    end
    tick();
    fr_we  = 1'b0;
    fr_we3 = 1'b0;
    chk({tag, ".wr_done"}, sel3 ? done3 : done, 1'b1);
    chk({tag, ".wr_err"}, sel3 ? err3 : err, exp_err);
    if (!exp_err) chk({tag, ".bus"}, sel3 ? bus_data3 : bus_data, exp_bus);
    if (wr_phase == 2) begin
      fr_waddr = wa; fr_wdata = wd;
      if (sel3) fr_we3 = 1'b1; else fr_we = 1'b1;
    end
    tick();
    fr_we  = 1'b0;
    fr_we3 = 1'b0;
    chk({tag, ".idle_done"}, sel3 ? done3 : done, 1'b0);
    chk({tag, ".idle_ready"}, sel3 ? cmd_ready3 : cmd_ready, 1'b1);
    chk({tag, ".idle_bus"}, sel3 ? bus_data3 : bus_data, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] dv, rv;
    logic       seen;
    rst = 1'b0;
    fr_we = 1'b0; fr_we3 = 1'b0; fr_waddr = '0; fr_wdata = '0;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_ch = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    // 1 reset state
    chk("rst.ch_data", ch_data, 16'h0000);
    chk("rst.bus", bus_data, 8'h00);
    chk("rst.ready", cmd_ready, 1'b1);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst3.ch_data", ch_data3, 24'h000000);
    chk("rst3.ready", cmd_ready3, 1'b1);

    // 2 LOAD
    wr(0, 5'd5, 8'hA5);
    run_cmd(0, 2'b00, 5'd5, 2'd1, 8'hA5, 0, 0, 5'd0, 8'h00, "load5");
    chk("load5.ch1", ch_data[15:8], 8'hA5);
    chk("load5.ch_data", ch_data, 16'hA500);

    // 3 STORE vs direct write
    wr(0, 5'd3, 8'h3C);
    run_cmd(0, 2'b00, 5'd3, 2'd1, 8'h3C, 0, 0, 5'd0, 8'h00, "load3");
    run_cmd(0, 2'b01, 5'd7, 2'd1, 8'h3C, 0, 2, 5'd7, 8'hFF, "store7");
    run_cmd(0, 2'b00, 5'd7, 2'd0, 8'h3C, 0, 0, 5'd0, 8'h00, "load7");
    chk("store_wins.ch_data", ch_data, 16'h3C3C);
    run_cmd(0, 2'b01, 5'd8, 2'd1, 8'h3C, 0, 2, 5'd9, 8'h77, "store8");
    run_cmd(0, 2'b00, 5'd8, 2'd0, 8'h3C, 0, 0, 5'd0, 8'h00, "load8");
    run_cmd(0, 2'b00, 5'd9, 2'd0, 8'h77, 0, 0, 5'd0, 8'h00, "load9");
    chk("both_commit.ch_data", ch_data, 16'h3C77);

    // 4 read hazard
    wr(0, 5'd2, 8'h11);
    run_cmd(0, 2'b00, 5'd2, 2'd0, 8'h11, 0, 1, 5'd2, 8'h22, "hazard");
    chk("hazard.ch_data", ch_data, 16'h3C11);
    run_cmd(0, 2'b00, 5'd2, 2'd1, 8'h22, 0, 0, 5'd0, 8'h00, "after_hazard");
    chk("after_hazard.ch_data", ch_data, 16'h2211);

    // 5 MOVE / CLEAR / held valid
    wr(0, 5'd10, 8'h5A);
    run_cmd(0, 2'b00, 5'd10, 2'd0, 8'h5A, 0, 0, 5'd0, 8'h00, "load10");
    chk("load10.ch_data", ch_data, 16'h225A);
    run_cmd(0, 2'b10, 5'd1, 2'd0, 8'h5A, 0, 0, 5'd0, 8'h00, "move01");
    chk("move01.ch_data", ch_data, 16'h5A5A);
    run_cmd(0, 2'b11, 5'd0, 2'd0, 8'h00, 0, 0, 5'd0, 8'h00, "clear0");
    chk("clear0.ch_data", ch_data, 16'h5A00);
    run_cmd(0, 2'b10, 5'd1, 2'd1, 8'h5A, 0, 0, 5'd0, 8'h00, "move11");
    chk("move11.ch_data", ch_data, 16'h5A00);
    cmd_op = 2'b11; cmd_addr = 5'd0; cmd_ch = 2'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      dv[i] = done;
      rv[i] = cmd_ready;
    end
    cmd_valid = 1'b0;
    chk("held.done_pattern", {23'd0, dv}, {23'd0, 9'b010010010});
    chk("held.ready_pattern", {23'd0, rv}, {23'd0, 9'b100100100});
    chk("held.ch_data", ch_data, 16'h0000);

    // 6 NCH=3, DEPTH=20
    wr(1, 5'd4, 8'hC3);
    run_cmd(1, 2'b00, 5'd4, 2'd2, 8'hC3, 0, 0, 5'd0, 8'h00, "n3.load_ch2");
    chk("n3.load_ch2.ch_data", ch_data3, 24'hC30000);
    run_cmd(1, 2'b00, 5'd4, 2'd3, 8'h00, 1, 0, 5'd0, 8'h00, "n3.load_ch3");
    chk("n3.load_ch3.ch_data", ch_data3, 24'hC30000);
    run_cmd(1, 2'b10, 5'd3, 2'd2, 8'h00, 1, 0, 5'd0, 8'h00, "n3.move_to3");
    chk("n3.move_to3.ch_data", ch_data3, 24'hC30000);
    run_cmd(1, 2'b00, 5'd4, 2'd0, 8'hC3, 0, 0, 5'd0, 8'h00, "n3.load_ch0");
    chk("n3.load_ch0.ch_data", ch_data3, 24'hC300C3);
    wr(1, 5'd25, 8'h99);
    run_cmd(1, 2'b00, 5'd25, 2'd0, 8'h00, 0, 0, 5'd0, 8'h00, "n3.oob_addr");
    chk("n3.oob_addr.ch_data", ch_data3, 24'hC30000);

    cmd_op = 2'b00; cmd_addr = 5'd4; cmd_ch = 2'd1; cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    chk("n3.rst_in_rd.busy", cmd_ready3, 1'b0);
    rst = 1'b0;
    #1;
    chk("n3.rst_in_rd.ch_data", ch_data3, 24'h000000);
    chk("n3.rst_in_rd.done", done3, 1'b0);
    tick(); tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | done3;
    end
    chk("n3.after_rst.no_done", seen, 1'b0);
    chk("n3.after_rst.ready", cmd_ready3, 1'b1);
    chk("n3.after_rst.ch_data", ch_data3, 24'h000000);
    run_cmd(1, 2'b00, 5'd4, 2'd1, 8'h00, 0, 0, 5'd0, 8'h00, "n3.file_cleared");
    chk("n3.file_cleared.ch_data", ch_data3, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
